// File: rtl/serial_subtractor_pkg.sv
// sersub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e         - control FSM states (IDLE, SHIFT, DONE)
//   SERSUB_DEFAULT_W - default operand width
//   cnt_width()     - bit counter width for a given W (at least 1 bit)
package sersub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int SERSUB_DEFAULT_W = 4;

  // $clog2(1) is 0, so clamp to keep the counter a legal 1-bit vector at W=1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done request bus of the serial subtractor.
//   start, a, b, bin : request (master -> slave)
//   busy, done       : status (slave -> master)
//   diff, bout       : result, held until the next operation completes
//   ovf              : two's-complement overflow, only with SERIAL_SUBTRACTOR_OVF_EN
interface serial_subtractor_if import sersub_pkg::*; #(parameter int W = SERSUB_DEFAULT_W);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational full subtractor, x - y - bi.
//   x, y, bi : minuend bit, subtrahend bit, borrow-in
//   d, bo    : difference bit, borrow-out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor, diff = a - b - bin, LSB first,
// one bit per clock through a single full-subtractor cell.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : serial_subtractor_if slave (start/a/b/bin in, busy/done/diff/bout out)
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output
// (two's-complement overflow of the subtraction).
module serial_subtractor import sersub_pkg::*; #(
  parameter int W = SERSUB_DEFAULT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = cnt_width(W);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           bout_q, bout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cell_d, cell_bo;
  logic           last;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else if (state_q == DONE) begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        // New bit enters at the MSB; after W shifts bit 0 has reached the LSB.
        // Shift-and-or form keeps W=1 legal (no zero-width slice).
        res_d    = (res_q >> 1) | (W'(cell_d) << (W - 1));
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = cell_bo;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          // Publish all result bits at once so diff never shows a partial value.
          diff_d  = res_d;
          bout_d  = cell_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the MSB step borrow_q is the borrow into the MSB.
          ovf_d   = borrow_q ^ cell_bo;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
